fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the decode stage (register-file read and immediate generation). Owns the program counter, issues in-order word requests to instruction memory over a valid/ready handshake, buffers returned words with their PCs in a small queue, and presents one instruction per cycle to decode. A redirect from execute (taken branch, JAL, JALR) flushes all buffered and in-flight fetches and restarts at the new target.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 2: queue entries, which is also the maximum number of in-flight plus buffered fetches; power of two, at least 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and forced to 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  instruction word returned; in order; cannot be back-pressured.
- imem_rsp_data  in  32  returned instruction word.
- if_valid  out  1  queue head holds a valid instruction.
- if_instr  out  32  instruction to decode.
- if_pc  out  32  PC of if_instr.
- id_ready  in  1  decode consumes the head this cycle (a stall is id_ready=0).

## Operation
- State:
  - pc: next address to request.
  - inflight: requests accepted but not yet returned, range 0..DEPTH.
  - drop: returns still to be discarded, with drop ≤ inflight.
  - Queue of {pc, instr} with occupancy count.
- Issue:
  - imem_req_valid = !redirect_valid && (inflight + count < DEPTH).
  - imem_req_addr = pc.
  - On handshake (valid && ready): pc += 4 (wraps mod 2^32), inflight += 1, and the issued PC is pushed into an internal PC-tag FIFO.
- Return:
  - On imem_rsp_valid: inflight -= 1.
  - If drop > 0: drop -= 1 and the word is discarded.
  - Otherwise {tag-FIFO head, imem_rsp_data} is written to the queue.
  - A response with inflight = 0 is a protocol error; assert it in simulation.
- Dequeue: if_valid && id_ready pops the head.
- Redirect (redirect_valid = 1):
  - Queue is emptied and the tag FIFO cleared.
  - pc ← {redirect_pc[31:2], 2'b00}.
  - drop ← inflight − (imem_rsp_valid ? 1 : 0), so every older fetch, including one returning this same cycle, is discarded.
  - No request is issued in the redirect cycle.
  - The pop by id_ready in the same cycle is ignored, because decode is flushed by the same signal.
- Simultaneous push and pop on a full queue is legal: occupancy stays unchanged. The credit rule guarantees a push never finds the queue full without a pop.
- Redirect while drop > 0: drop is recomputed from inflight by the same rule.

## Timing
- Reset values: pc = RESET_PC, inflight = 0, drop = 0, queue empty, if_valid = 0, if_instr = 32'h0000_0013 (NOP), if_pc = 0.
- imem_req_valid is 0 while rst_n = 0. The first request (addr RESET_PC) is asserted in the first cycle after rst_n rises.
- Reset asserted mid-operation discards all state. Responses arriving during or after reset for pre-reset requests must not occur; the memory is reset together with this block.
- Latency: a response accepted at edge N appears at if_valid/if_instr after edge N. The queue is registered, with no response-to-output bypass.
- The redirect target is requested in the cycle after redirect_valid. Minimum redirect-to-if_valid time = memory latency + 1 cycle.
- Steady state with single-cycle memory and DEPTH = 2: one instruction per cycle when id_ready = 1.
- if_instr and if_pc hold stable while if_valid && !id_ready.

## Structure
- Shared package rv_pkg holds: XLEN = 32, the NOP constant 32'h0000_0013, and the default RESET_PC.
- One sub-module, fetch_fifo: a synchronous FIFO parameterised by width and DEPTH, with push, pop, flush, full, empty and count. It is instantiated twice:
  - 64-bit {pc, instr} queue.
  - 32-bit PC-tag FIFO.
- fetch_unit holds the pc, inflight and drop counters and the issue/redirect logic.

## Test plan
- Reset, memory always ready, 1-cycle latency, id_ready = 1 → requests to addresses 0, 4, 8, …; if_valid first rises 2 cycles after reset release; if_pc increments by 4 with the matching words.
- Decode stall: id_ready = 0 for 5 cycles with DEPTH = 2 → at most 2 requests outstanding or buffered; no request issued while full; if_instr/if_pc held; no word lost or duplicated after release.
- Redirect to 32'h0000_0103 with 2 fetches in flight → next request address is 32'h0000_0100; both old responses discarded; first if_pc after the redirect is 32'h0000_0100.
- Redirect in the same cycle as a response and a decode pop → response dropped; queue empty next cycle; drop equals the remaining inflight.
- imem_req_ready low for 3 cycles, then variable 1–3 cycle response latency → in-order delivery, correct PC tags, inflight never exceeds DEPTH.
- PC wrap: redirect to 32'hFFFF_FFFC → consecutive requests to 32'hFFFF_FFFC then 32'h0000_0000.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV core definitions: datapath width, canonical NOP and default reset PC.
// Also provides word alignment of fetch targets.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage boundary signals: execute redirect, imem request/response, decode handoff.
// The master modport is the fetch unit's view of these signals.
interface fetch_unit_if;
  import rv_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used for the instruction queue and the PC-tag FIFO.
// A push to a full FIFO is accepted when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && rst_n && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem requests under a credit limit,
// queues returned words with their PCs for decode, and flushes on execute redirects.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   pc;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     drop;
  logic [CW:0]       occupancy;
  logic              redirect;
  logic              rsp;
  logic              issue;
  logic              rsp_keep;
  logic              q_pop;
  logic [2*XLEN-1:0] q_head;
  logic [CW-1:0]     q_count;
  logic              q_full;
  logic              q_empty;
  logic [XLEN-1:0]   tag_head;
  logic [CW-1:0]     tag_count;
  logic              tag_full;
  logic              tag_empty;

  // Credit counts in-flight (including to-be-dropped) plus buffered entries,
  // so a kept response always finds room in the queue.
  always_comb begin
    redirect            = bus.redirect_valid;
    rsp                 = bus.imem_rsp_valid;
    occupancy           = {1'b0, inflight} + {1'b0, q_count};
    bus.imem_req_valid  = rst_n && !redirect && (occupancy < (CW+1)'(DEPTH));
    bus.imem_req_addr   = pc;
    issue               = bus.imem_req_valid && bus.imem_req_ready;
    rsp_keep            = rsp && (drop == '0) && !redirect;
    q_pop               = !q_empty && bus.id_ready && !redirect;
    bus.if_valid        = !q_empty;
    bus.if_instr        = q_empty ? NOP : q_head[XLEN-1:0];
    bus.if_pc           = q_empty ? '0  : q_head[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect) begin
      // Every older fetch, including one returning right now, must be discarded.
      pc       <= word_align(bus.redirect_pc);
      inflight <= inflight - CW'(rsp);
      drop     <= inflight - CW'(rsp);
    end else begin
      if (issue) pc <= pc + XLEN'(4);
      inflight <= inflight + CW'(issue) - CW'(rsp);
      if (rsp && (drop != '0)) drop <= drop - CW'(1);
    end
  end

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (rsp_keep),
    .push_data ({tag_head, bus.imem_rsp_data}),
    .pop       (q_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tags (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (issue),
    .push_data (pc),
    .pop       (rsp_keep),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  a_rsp_without_req:  assert property (@(posedge clk) disable iff (!rst_n) rsp |-> (inflight != '0));
  a_queue_overflow:   assert property (@(posedge clk) disable iff (!rst_n) rsp_keep |-> (!q_full || q_pop));
  a_tag_overflow:     assert property (@(posedge clk) disable iff (!rst_n) issue |-> !tag_full);
  a_tag_underflow:    assert property (@(posedge clk) disable iff (!rst_n) rsp_keep |-> !tag_empty);
  a_tag_consistency:  assert property (@(posedge clk) disable iff (!rst_n) tag_count == (inflight - drop));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: expected {pc, instr} stream is built from
// the sequential-PC rule and redirect targets; a monitor checks what decode receives.
module tb_fetch_unit;
  import rv_pkg::*;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          stale;
  } mem_req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_req_t    pending[$];
  exp_t        sb[$];
  logic [31:0] model_pc = RESET_PC;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned n_pops = 0;
  int unsigned rdy_pct = 100;
  int unsigned idr_pct = 100;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_le(input string name, input int unsigned act, input int unsigned lim);
    n_checks++;
    if (act > lim) begin
      n_fail++;
      $display("FAIL %s: got %0d, must be <= %0d (cycle %0d)", name, act, lim, cyc);
    end
  endtask

  task automatic chk_ge(input string name, input int unsigned act, input int unsigned lim);
    n_checks++;
    if (act < lim) begin
      n_fail++;
      $display("FAIL %s: got %0d, must be >= %0d (cycle %0d)", name, act, lim, cyc);
    end
  endtask

  // One clock: memory presents its oldest due response, random handshake inputs driven.
  task automatic cycle(input bit redir, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    cyc++;
    if (pending.size() != 0 && pending[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    bus.id_ready       = ($urandom_range(99) < idr_pct);
    bus.redirect_valid = redir;
    bus.redirect_pc    = redir ? tgt : $urandom;
  endtask

  // Request side: checks addresses and credit, pushes expected entries, models redirects.
  always @(negedge clk) begin : issue_side
    int unsigned stale_n;
    int unsigned occ;
    if (rst_n) begin
      stale_n = 0;
      foreach (pending[i]) if (pending[i].stale) stale_n++;
      occ = sb.size() + stale_n;
      chk_le("occupancy", occ, DEPTH);
      chk_le("inflight", pending.size() + 32'(bus.imem_rsp_valid), DEPTH);
      if (bus.imem_req_valid) chk_le("req_while_full", occ + 1, DEPTH);
      if (bus.redirect_valid) begin
        chk("req_in_redirect", 32'(bus.imem_req_valid), 32'd0);
        sb.delete();
        foreach (pending[i]) pending[i].stale = 1'b1;
        model_pc = bus.redirect_pc & 32'hFFFF_FFFC;
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("req_addr", bus.imem_req_addr, model_pc);
        sb.push_back(exp_t'{pc: model_pc, instr: mem_word(model_pc)});
        pending.push_back(mem_req_t'{addr: bus.imem_req_addr,
                                     due: cyc + $urandom_range(lat_max, lat_min),
                                     stale: 1'b0});
        model_pc = model_pc + 32'd4;
      end
    end
  end

  // Decode side: whatever is presented must be the oldest surviving fetch.
  always @(negedge clk) begin : monitor
    if (rst_n && !bus.redirect_valid && bus.if_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL if_unexpected: got if_pc %h, expected no valid output (cycle %0d)", bus.if_pc, cyc);
      end else begin
        chk("if_pc", bus.if_pc, sb[0].pc);
        chk("if_instr", bus.if_instr, sb[0].instr);
        if (bus.id_ready) begin
          void'(sb.pop_front());
          n_pops++;
        end
      end
    end
  end

  initial begin : main
    int unsigned p0;
    bit found;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.id_ready       = 1'b0;

    repeat (3) cycle(1'b0, 32'h0);
    #3;
    chk("reset_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("reset_if_valid", 32'(bus.if_valid), 32'd0);
    chk("reset_if_instr", bus.if_instr, NOP);
    chk("reset_if_pc", bus.if_pc, 32'h0);

    // Release: first request now, word visible two cycles later.
    cycle(1'b0, 32'h0);
    rst_n = 1'b1;
    #3;
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, RESET_PC);
    chk("if_valid_c1", 32'(bus.if_valid), 32'd0);
    cycle(1'b0, 32'h0);
    #3;
    chk("if_valid_c2", 32'(bus.if_valid), 32'd0);
    cycle(1'b0, 32'h0);
    #3;
    chk("if_valid_c3", 32'(bus.if_valid), 32'd1);
    repeat (17) cycle(1'b0, 32'h0);
    chk_ge("progress_stream", n_pops, 10);

    // Decode stall for 5 cycles.
    idr_pct = 0;
    cycle(1'b0, 32'h0);
    p0 = n_pops;
    repeat (4) cycle(1'b0, 32'h0);
    chk("no_pop_in_stall", n_pops, p0);
    idr_pct = 100;
    repeat (10) cycle(1'b0, 32'h0);
    chk_ge("progress_after_stall", n_pops, p0 + 4);

    // Redirect to an unaligned target with two fetches outstanding.
    lat_min = 3;
    lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1'b0, 32'h0);
      if (pending.size() == 2) found = 1'b1;
    end
    chk("two_inflight_reached", 32'(found), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    p0 = n_pops;
    cycle(1'b0, 32'h0);
    #3;
    chk("empty_after_redirect", 32'(bus.if_valid), 32'd0);
    repeat (20) cycle(1'b0, 32'h0);
    chk_ge("progress_after_redirect", n_pops, p0 + 2);

    // Memory not ready for 3 cycles, then variable latency.
    lat_min = 1;
    lat_max = 3;
    rdy_pct = 0;
    repeat (3) cycle(1'b0, 32'h0);
    rdy_pct = 100;
    p0 = n_pops;
    repeat (30) cycle(1'b0, 32'h0);
    chk_ge("progress_var_latency", n_pops, p0 + 8);

    // PC wrap.
    lat_max = 1;
    p0 = n_pops;
    cycle(1'b1, 32'hFFFF_FFFC);
    repeat (12) cycle(1'b0, 32'h0);
    chk_ge("progress_wrap", n_pops, p0 + 4);

    // Random mix of stalls, back-pressure, latencies and redirects.
    rdy_pct = 70;
    idr_pct = 70;
    lat_max = 3;
    p0 = n_pops;
    for (int i = 0; i < 3000; i++) begin
      bit          redir;
      logic [31:0] tgt;
      redir = ($urandom_range(99) < 4);
      tgt   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      cycle(redir, tgt);
    end
    chk_ge("progress_random", n_pops, p0 + 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
